// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: one-hot row drive, column sync, press/release debounce,
// multi-key error pulse. Current FSM state is visible on o_dbg_state.
module keypad_scanner #(
  parameter int NROWS    = 4,
  parameter int NCOLS    = 4,
  parameter int SCAN_DIV = 16,
  parameter int DEBOUNCE = 8,
  localparam int KW      = $clog2(NROWS*NCOLS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCOLS-1:0] c,
  output logic [NROWS-1:0] r,
  output logic [KW-1:0]    key_code,
  output logic             key_valid,
  output logic             key_held,
  output logic             multi_err,
  output logic [1:0]       o_dbg_state
);

  localparam int RW = $clog2(NROWS);
  localparam int CW = $clog2(NCOLS);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE+1);

  localparam logic [RW-1:0] ROW_LAST  = RW'(NROWS-1);
  localparam logic [DW-1:0] DWELL_END = DW'(SCAN_DIV-1);
  localparam logic [BW-1:0] CNT_LAST  = BW'(DEBOUNCE-1);
  localparam logic [BW-1:0] CNT_MAX   = BW'(DEBOUNCE);

  typedef enum logic [1:0] {
    ST_SCAN       = 2'd0,
    ST_PRESS_DB   = 2'd1,
    ST_HELD       = 2'd2,
    ST_RELEASE_DB = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [NCOLS-1:0] r_c_meta, r_cs;
  logic [RW-1:0]    r_row, w_row_nxt;
  logic [DW-1:0]    r_dwell, w_dwell_nxt;
  logic [BW-1:0]    r_cnt, w_cnt_nxt;
  logic [CW-1:0]    r_cap_col, w_cap_col_nxt;
  logic [KW-1:0]    r_key_code, w_code_nxt;
  logic             r_key_valid, w_valid_nxt;
  logic             r_key_held, w_held_nxt;
  logic             r_multi_err, w_err_nxt;

  logic [RW-1:0]    w_row_inc;
  logic [BW-1:0]    w_cnt_inc;
  logic [CW-1:0]    w_idx;
  logic [KW-1:0]    w_code;
  logic             w_any, w_multi, w_match, w_cap_bit, w_dwell_last;

  // While a key is captured r_row is not advanced, so it doubles as the captured row.
  assign w_row_inc    = (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
  assign w_cnt_inc    = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
  assign w_dwell_last = (r_dwell == DWELL_END);
  assign w_any        = |r_cs;
  assign w_multi      = |(r_cs & (r_cs - 1'b1));
  assign w_match      = (r_cs == (NCOLS'(1) << r_cap_col));
  assign w_cap_bit    = r_cs[r_cap_col];
  assign w_code       = KW'(int'(r_row) * NCOLS + int'(r_cap_col));

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NCOLS; i++) begin
      if (r_cs[i]) w_idx = i[CW-1:0];
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_row_nxt     = r_row;
    w_dwell_nxt   = r_dwell;
    w_cnt_nxt     = r_cnt;
    w_cap_col_nxt = r_cap_col;
    w_code_nxt    = r_key_code;
    w_valid_nxt   = 1'b0;
    w_held_nxt    = r_key_held;
    w_err_nxt     = 1'b0;
    case (r_state)
      ST_SCAN: begin
        if (!w_dwell_last) begin
          w_dwell_nxt = r_dwell + 1'b1;
        end else begin
          w_dwell_nxt = '0;
          if (!w_any) begin
            w_row_nxt = w_row_inc;
          end else if (w_multi) begin
            w_err_nxt = 1'b1;
            w_row_nxt = w_row_inc;
          end else begin
            w_cap_col_nxt = w_idx;
            w_cnt_nxt     = '0;
            w_state_nxt   = ST_PRESS_DB;
          end
        end
      end
      ST_PRESS_DB: begin
        if (!w_match) begin
          w_state_nxt = ST_SCAN;
          w_row_nxt   = w_row_inc;
          w_dwell_nxt = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = ST_HELD;
            w_valid_nxt = 1'b1;
            w_code_nxt  = w_code;
            w_held_nxt  = 1'b1;
          end
        end
      end
      ST_HELD: begin
        if (!w_cap_bit) begin
          w_state_nxt = ST_RELEASE_DB;
          w_cnt_nxt   = '0;
        end
      end
      ST_RELEASE_DB: begin
        if (w_cap_bit) begin
          w_state_nxt = ST_HELD;
        end else begin
          w_cnt_nxt = w_cnt_inc;
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = ST_SCAN;
            w_row_nxt   = w_row_inc;
            w_dwell_nxt = '0;
            w_held_nxt  = 1'b0;
          end
        end
      end
      default: w_state_nxt = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_SCAN;
      r_c_meta    <= '0;
      r_cs        <= '0;
      r_row       <= '0;
      r_dwell     <= '0;
      r_cnt       <= '0;
      r_cap_col   <= '0;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
      r_multi_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_c_meta    <= c;
      r_cs        <= r_c_meta;
      r_row       <= w_row_nxt;
      r_dwell     <= w_dwell_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cap_col   <= w_cap_col_nxt;
      r_key_code  <= w_code_nxt;
      r_key_valid <= w_valid_nxt;
      r_key_held  <= w_held_nxt;
      r_multi_err <= w_err_nxt;
    end
  end

  assign r           = NROWS'(1) << r_row;
  assign key_code    = r_key_code;
  assign key_valid   = r_key_valid;
  assign key_held    = r_key_held;
  assign multi_err   = r_multi_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a simulated 4x4 key matrix drives c from r; a
// cycle-level reference model predicts every output after each clock edge.
module tb_keypad_scanner;

  localparam int NROWS = 4;
  localparam int NCOLS = 4;
  localparam int SDIV  = 4;
  localparam int DEB   = 3;
  localparam int M_SCAN = 0, M_PRESS = 1, M_HELD = 2, M_REL = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] c = '0;
  logic [3:0] r;
  logic [3:0] key_code;
  logic       key_valid, key_held, multi_err;
  logic [1:0] dbg_state;

  int n_assert = 0;
  int n_fail   = 0;
  int n_vp     = 0;
  int n_ep     = 0;

  // reference model state
  int         m_mode, m_row, m_tick, m_cnt, m_crow, m_ccol, m_code;
  bit         m_valid, m_held, m_err;
  logic [3:0] m_sync_q[$];

  keypad_scanner #(.NROWS(NROWS), .NCOLS(NCOLS), .SCAN_DIV(SDIV), .DEBOUNCE(DEB)) dut (
    .clk(clk), .reset(reset), .c(c), .r(r), .key_code(key_code),
    .key_valid(key_valid), .key_held(key_held), .multi_err(multi_err),
    .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Column pattern a physical matrix would present for the currently driven row.
  function automatic logic [3:0] cols_of(input logic [15:0] mask, input logic [3:0] rv);
    logic [3:0] res = '0;
    for (int i = 0; i < NROWS; i++)
      if (rv === (4'b0001 << i)) res = mask[i*NCOLS +: NCOLS];
    return res;
  endfunction

  task automatic model_step(input bit rst, input logic [3:0] cin);
    logic [3:0] cs;
    if (rst) begin
      m_mode = M_SCAN; m_row = 0; m_tick = 0; m_cnt = 0; m_crow = 0; m_ccol = 0;
      m_code = 0; m_valid = 0; m_held = 0; m_err = 0;
      m_sync_q = '{4'b0, 4'b0};
      return;
    end
    cs = m_sync_q.pop_front();
    m_sync_q.push_back(cin);
    m_valid = 0;
    m_err = 0;
    case (m_mode)
      M_SCAN: begin
        if (m_tick < SDIV-1) m_tick++;
        else begin
          m_tick = 0;
          if ($countones(cs) == 0) m_row = (m_row + 1) % NROWS;
          else if ($countones(cs) > 1) begin m_err = 1; m_row = (m_row + 1) % NROWS; end
          else begin
            for (int i = 0; i < NCOLS; i++) if (cs[i]) m_ccol = i;
            m_crow = m_row; m_cnt = 0; m_mode = M_PRESS;
          end
        end
      end
      M_PRESS: begin
        if (cs == (4'b0001 << m_ccol)) begin
          m_cnt++;
          if (m_cnt == DEB) begin
            m_mode = M_HELD; m_valid = 1; m_held = 1; m_code = m_crow*NCOLS + m_ccol;
          end
        end else begin
          m_mode = M_SCAN; m_row = (m_crow + 1) % NROWS; m_tick = 0;
        end
      end
      M_HELD: if (!cs[m_ccol]) begin m_mode = M_REL; m_cnt = 0; end
      default: begin
        if (cs[m_ccol]) m_mode = M_HELD;
        else begin
          m_cnt++;
          if (m_cnt == DEB) begin
            m_mode = M_SCAN; m_row = (m_crow + 1) % NROWS; m_tick = 0; m_held = 0;
          end
        end
      end
    endcase
  endtask

  task automatic check_all();
    int row_now;
    row_now = (m_mode == M_SCAN) ? m_row : m_crow;
    chk("r", r, 32'(4'b0001 << row_now));
    chk("key_code", key_code, 32'(m_code));
    chk("key_valid", key_valid, 32'(m_valid));
    chk("key_held", key_held, 32'(m_held));
    chk("multi_err", multi_err, 32'(m_err));
    chk("state", dbg_state, 32'(m_mode));
    chk("r_onehot", 32'($onehot(r)), 1);
    chk("valid_err_excl", 32'(key_valid & multi_err), 0);
  endtask

  // One clock: drive inputs at negedge, advance model, sample 1 time unit after posedge.
  task automatic tick(input bit rst, input logic [15:0] mask);
    @(negedge clk);
    reset = rst;
    c = cols_of(mask, r);
    model_step(rst, c);
    @(posedge clk);
    #1;
    check_all();
    if (key_valid) n_vp++;
    if (multi_err) n_ep++;
  endtask

  initial begin
    int vp0, ep0, budget, kind, dur, k, k2;
    logic [15:0] mask;

    // reset and idle row rotation
    tick(1, 16'h0);
    chk("rst_r", r, 4'b0001);
    chk("rst_code", key_code, 0);
    chk("rst_held", key_held, 0);
    chk("rst_state", dbg_state, 0);
    repeat (4) tick(0, 16'h0);
    chk("scan_row1", r, 4'b0010);
    repeat (4) tick(0, 16'h0);
    chk("scan_row2", r, 4'b0100);
    repeat (4) tick(0, 16'h0);
    chk("scan_row3", r, 4'b1000);
    repeat (4) tick(0, 16'h0);
    chk("scan_wrap", r, 4'b0001);

    // press key 9 (row 2, col 1)
    vp0 = n_vp;
    budget = 60;
    while (budget > 0 && !key_held) begin tick(0, 16'h0200); budget--; end
    chk("press_held", key_held, 1);
    chk("press_pulses", n_vp - vp0, 1);
    chk("press_code", key_code, 9);
    repeat (8) tick(0, 16'h0200);
    chk("press_r_frozen", r, 4'b0100);
    chk("press_no_refire", n_vp - vp0, 1);

    // release bounce, then full release
    tick(0, 16'h0);
    repeat (6) tick(0, 16'h0200);
    chk("bounce_held", key_held, 1);
    chk("bounce_no_pulse", n_vp - vp0, 1);
    budget = 20;
    while (budget > 0 && key_held) begin tick(0, 16'h0); budget--; end
    chk("release_held", key_held, 0);
    chk("release_r", r, 4'b1000);

    // 1-cycle glitch at row 2 sample point
    budget = 40;
    while (budget > 0 && r !== 4'b0100) begin tick(0, 16'h0); budget--; end
    chk("glitch_at_row2", r, 4'b0100);
    tick(0, 16'h0);
    tick(0, 16'h0200);
    tick(0, 16'h0);
    tick(0, 16'h0);
    chk("glitch_captured", dbg_state, M_PRESS);
    tick(0, 16'h0);
    chk("glitch_resume_r", r, 4'b1000);
    chk("glitch_no_pulse", n_vp - vp0, 1);

    // two columns in row 1
    ep0 = n_ep;
    budget = 40;
    while (budget > 0 && r !== 4'b0100) begin tick(0, 16'h0090); budget--; end
    chk("multi_r_adv", r, 4'b0100);
    repeat (2) tick(0, 16'h0);
    chk("multi_pulses", n_ep - ep0, 1);
    chk("multi_no_valid", n_vp - vp0, 1);

    // reset while held
    budget = 60;
    while (budget > 0 && !key_held) begin tick(0, 16'h0200); budget--; end
    chk("pre_rst_held", key_held, 1);
    tick(1, 16'h0200);
    chk("midrst_r", r, 4'b0001);
    chk("midrst_held", key_held, 0);
    chk("midrst_code", key_code, 0);
    chk("midrst_state", dbg_state, 0);
    repeat (3) tick(0, 16'h0);

    // randomized episodes against the model
    for (int ep = 0; ep < 120; ep++) begin
      kind = $urandom_range(0, 9);
      k  = $urandom_range(0, 15);
      k2 = $urandom_range(0, 15);
      mask = 16'(1) << k;
      case (kind)
        0, 1: repeat ($urandom_range(4, 30)) tick(0, 16'h0);
        2, 3, 4: repeat ($urandom_range(20, 80)) tick(0, mask);
        5: repeat ($urandom_range(1, 6)) tick(0, mask);
        6: repeat ($urandom_range(10, 60)) tick(0, mask | (16'(1) << k2));
        7: begin
          dur = $urandom_range(30, 60);
          repeat (dur) tick(0, ($urandom_range(0, 3) == 0) ? 16'h0 : mask);
        end
        8: begin
          repeat ($urandom_range(20, 40)) tick(0, mask);
          repeat ($urandom_range(5, 30)) tick(0, mask | (16'(1) << k2));
        end
        default: begin
          repeat ($urandom_range(0, 20)) tick(0, mask);
          tick(1, mask);
        end
      endcase
      repeat ($urandom_range(0, 20)) tick(0, 16'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
